icache_responder: RTL and testbench

- Instruction-cache responder: the cache side of the fetch-to-icache request/response protocol.
- Accepts fetch requests as idx/vpn/valid/kill/invalidate.
- Returns a 128-bit line plus its vaddr; misses are refilled from a simple memory port.
- Direct-mapped, 16-byte lines, virtually indexed and virtually tagged (no translation).
- Sits between the fetch-side icache interface and the L2/memory model.

---
 rtl/icache_responder.sv | 138 +++++++++++++
 tb/tb_icache_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped VIVT icache responder: hits respond 1 cycle after accept, misses refill via mem port.
// Request ready drops during miss handling and invalidate; mem request held stable until mem_req_ready_i.
module icache_responder #(
  parameter int VADDR_W  = 40,
  parameter int NUM_SETS = 64,
  parameter int LINE_W   = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                icache_req_valid_i,
  input  logic [11:0]         icache_req_bits_idx_i,
  input  logic [VADDR_W-13:0] icache_req_bits_vpn_i,
  input  logic                icache_req_kill_i,
  input  logic                icache_invalidate_i,
  output logic                icache_req_ready_o,
  output logic                icache_resp_valid_o,
  output logic [LINE_W-1:0]   icache_resp_datablock_o,
  output logic [VADDR_W-1:0]  icache_resp_vaddr_o,
  output logic                mem_req_valid_o,
  output logic [VADDR_W-1:0]  mem_req_addr_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_resp_valid_i,
  input  logic [LINE_W-1:0]   mem_resp_data_i
);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int LADDR_W = VADDR_W - 4;
  localparam int TAG_W   = LADDR_W - IDX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] MISS_REQ  = 2'd2;
  localparam logic [1:0] MISS_WAIT = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [LADDR_W-1:0] line_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [LINE_W-1:0]  data_mem [NUM_SETS];
  logic [TAG_W-1:0]   tag_mem  [NUM_SETS];
  logic               killed_q;
  logic               pending_inval_q;
  logic               refill_vld_q;
  logic [LINE_W-1:0]  refill_data_q;
  logic [VADDR_W-1:0] refill_vaddr_q;
  logic               mem_req_vld_q;
  logic [VADDR_W-1:0] mem_req_addr_q;

  logic [IDX_W-1:0]   set_w;
  logic [TAG_W-1:0]   tag_w;
  logic [LADDR_W-1:0] req_line_w;
  logic               in_lookup, hit, lookup_hit, accept, fill, idle_or_lookup;
  logic               unused_idx_bits;

  assign set_w          = line_q[IDX_W-1:0];
  assign tag_w          = line_q[LADDR_W-1:IDX_W];
  assign req_line_w     = {icache_req_bits_vpn_i, icache_req_bits_idx_i[11:4]};
  assign unused_idx_bits = ^icache_req_bits_idx_i[3:0];

  assign in_lookup      = (state_q == LOOKUP);
  assign idle_or_lookup = (state_q == IDLE) || in_lookup;
  assign hit            = valid_q[set_w] && (tag_mem[set_w] == tag_w);
  assign lookup_hit     = in_lookup && hit;
  assign fill           = (state_q == MISS_WAIT) && mem_resp_valid_i;

  assign icache_req_ready_o = !icache_invalidate_i &&
                              ((state_q == IDLE) || (lookup_hit && !icache_req_kill_i));
  assign accept             = icache_req_valid_i && icache_req_ready_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP:    if (!hit) state_d = MISS_REQ;
                 else if (accept) state_d = LOOKUP;
                 else state_d = IDLE;
      MISS_REQ:  if (mem_req_ready_i) state_d = MISS_WAIT;
      MISS_WAIT: if (mem_resp_valid_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      line_q          <= '0;
      valid_q         <= '0;
      killed_q        <= 1'b0;
      pending_inval_q <= 1'b0;
      refill_vld_q    <= 1'b0;
      refill_data_q   <= '0;
      refill_vaddr_q  <= '0;
      mem_req_vld_q   <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) line_q <= req_line_w;

      if (state_d == IDLE) killed_q <= 1'b0;
      else if (icache_req_kill_i && (state_q != IDLE)) killed_q <= 1'b1;

      // An invalidate racing a refill leaves that line invalid; the response still goes out.
      if (icache_invalidate_i && idle_or_lookup) valid_q <= '0;
      else if (fill) begin
        if (pending_inval_q || icache_invalidate_i) valid_q <= '0;
        else valid_q[set_w] <= 1'b1;
      end

      if (fill) pending_inval_q <= 1'b0;
      else if (icache_invalidate_i && !idle_or_lookup) pending_inval_q <= 1'b1;

      if (in_lookup && !hit) begin
        mem_req_vld_q  <= 1'b1;
        mem_req_addr_q <= {line_q, 4'b0};
      end else if ((state_q == MISS_REQ) && mem_req_ready_i) begin
        mem_req_vld_q  <= 1'b0;
      end

      refill_vld_q <= fill && !killed_q && !icache_req_kill_i;
      if (fill) begin
        refill_data_q  <= mem_resp_data_i;
        refill_vaddr_q <= {line_q, 4'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill && !rst_i) begin
      data_mem[set_w] <= mem_resp_data_i;
      tag_mem[set_w]  <= tag_w;
    end
  end

  assign icache_resp_valid_o     = (lookup_hit && !icache_req_kill_i) || refill_vld_q;
  assign icache_resp_datablock_o = in_lookup ? data_mem[set_w] : refill_data_q;
  assign icache_resp_vaddr_o     = in_lookup ? {line_q, 4'b0} : refill_vaddr_q;
  assign mem_req_valid_o         = mem_req_vld_q;
  assign mem_req_addr_o          = mem_req_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: transaction-level cache model (valid/tag/data per set) plus
// a per-cycle compare process on response, ready and memory-request outputs.
module tb_icache_responder;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid;
  logic [11:0]  req_idx;
  logic [27:0]  req_vpn;
  logic         kill, inv;
  logic         ready, resp_valid;
  logic [127:0] resp_data;
  logic [39:0]  resp_vaddr;
  logic         mreq_valid;
  logic [39:0]  mreq_addr;
  logic         mreq_ready, mresp_valid;
  logic [127:0] mresp_data;

  icache_responder #(.VADDR_W(40), .NUM_SETS(64), .LINE_W(128)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .icache_req_valid_i      (req_valid),
    .icache_req_bits_idx_i   (req_idx),
    .icache_req_bits_vpn_i   (req_vpn),
    .icache_req_kill_i       (kill),
    .icache_invalidate_i     (inv),
    .icache_req_ready_o      (ready),
    .icache_resp_valid_o     (resp_valid),
    .icache_resp_datablock_o (resp_data),
    .icache_resp_vaddr_o     (resp_vaddr),
    .mem_req_valid_o         (mreq_valid),
    .mem_req_addr_o          (mreq_addr),
    .mem_req_ready_i         (mreq_ready),
    .mem_resp_valid_i        (mresp_valid),
    .mem_resp_data_i         (mresp_data)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  // Cache model: what the line state must be after each completed transaction.
  bit [63:0]    mvalid;
  logic [29:0]  mtag  [64];
  logic [127:0] mdata [64];

  // Expected outputs for the current cycle.
  bit           cmp_en = 1'b0;
  bit           exp_resp, exp_rdy, exp_mreq;
  logic [127:0] exp_data;
  logic [39:0]  exp_vaddr, exp_maddr;

  function automatic logic [127:0] mem_line(input logic [39:0] a);
    return {32'hC0DE_0000, a[31:0], ~a[31:0], a[31:0] ^ 32'h5A5A_5A5A};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("resp_valid", resp_valid, exp_resp);
      if (exp_resp) begin
        chk("resp_data", resp_data, exp_data);
        chk("resp_vaddr", resp_vaddr, exp_vaddr);
      end
      chk("req_ready", ready, exp_rdy);
      chk("mem_req_valid", mreq_valid, exp_mreq);
      if (exp_mreq) chk("mem_req_addr", mreq_addr, exp_maddr);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    req_valid = 0; kill = 0; inv = 0; mreq_ready = 0; mresp_valid = 0;
    exp_resp = 0; exp_rdy = 1;
  endtask

  // One fetch request from an IDLE or clean-hit LOOKUP cycle. kph/iph: 0 none,
  // 1 in LOOKUP, 2 in first MISS_WAIT cycle, 3 coincident with mem response.
  // Returns in the response cycle (hit: LOOKUP, miss: the IDLE cycle after refill).
  task automatic txn(input logic [39:0] a, input int kph, input int iph);
    logic [5:0]  s;
    logic [29:0] tg;
    logic [39:0] line;
    bit hit, killed, pend;
    int w, d;
    s = a[9:4]; tg = a[39:10]; line = {a[39:4], 4'b0};
    hit = mvalid[s] && (mtag[s] == tg);
    req_valid = 1; req_idx = a[11:0]; req_vpn = a[39:12];
    step();
    if (hit) begin
      if (kph == 1) kill = 1;
      if (iph == 1) inv = 1;
      exp_rdy = (kph != 1) && (iph != 1);
      if (kph != 1) begin exp_resp = 1; exp_data = mdata[s]; exp_vaddr = line; end
      if (iph == 1) mvalid = '0;
      if (!exp_rdy) step();
    end else begin
      killed = (kph == 1); pend = 0;
      if (kph == 1) kill = 1;
      if (iph == 1) begin inv = 1; mvalid = '0; end
      exp_rdy = 0;
      w = $urandom_range(0, 2);
      d = (kph == 2 || iph == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      for (int i = 0; i <= w; i++) begin
        step(); exp_rdy = 0; exp_mreq = 1; exp_maddr = line; mreq_ready = (i == w);
      end
      for (int i = 0; i < d; i++) begin
        step(); exp_rdy = 0; exp_mreq = 0;
        if (i == 0 && kph == 2) begin kill = 1; killed = 1; end
        if (i == 0 && iph == 2) begin inv = 1; pend = 1; end
      end
      step(); exp_rdy = 0; exp_mreq = 0;
      mresp_valid = 1; mresp_data = mem_line(line);
      if (kph == 3) begin kill = 1; killed = 1; end
      if (iph == 3) begin inv = 1; pend = 1; end
      step();
      if (!killed) begin exp_resp = 1; exp_data = mem_line(line); exp_vaddr = line; end
      if (pend) mvalid = '0;
      else begin mvalid[s] = 1; mtag[s] = tg; mdata[s] = mem_line(line); end
    end
  endtask

  task automatic idle_inval();
    inv = 1; exp_rdy = 0; mvalid = '0;
    step();
  endtask

  initial begin
    logic [39:0] a;
    int r, kph, iph;
    rst_i = 1; req_valid = 0; req_idx = '0; req_vpn = '0; kill = 0; inv = 0;
    mreq_ready = 0; mresp_valid = 0; mresp_data = '0;
    exp_resp = 0; exp_rdy = 1; exp_mreq = 0; exp_data = '0; exp_vaddr = '0; exp_maddr = '0;
    mvalid = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 0;
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_ready", ready, 1'b1);
    chk("reset_mem_req_valid", mreq_valid, 1'b0);
    chk("reset_datablock", resp_data, 128'h0);
    chk("reset_vaddr", resp_vaddr, 40'h0);
    chk("reset_mem_req_addr", mreq_addr, 40'h0);
    cmp_en = 1;

    // First miss then hit on 0x1230
    txn(40'h00_0000_1230, 0, 0);
    chk("first_fill_mem_addr", mreq_addr, 40'h00_0000_1230);
    chk("first_fill_resp", resp_valid, 1'b1);
    chk("first_fill_data", resp_data, 128'hC0DE0000_00001230_FFFFEDCF_5A5A486A);
    chk("first_fill_vaddr", resp_vaddr, 40'h00_0000_1230);
    step();
    txn(40'h00_0000_1230, 0, 0);
    chk("first_hit_resp", resp_valid, 1'b1);
    chk("first_hit_data", resp_data, 128'hC0DE0000_00001230_FFFFEDCF_5A5A486A);
    step();

    // Back-to-back hits on 0x1230 / 0x1240
    txn(40'h00_0000_1240, 0, 0);
    step();
    txn(40'h00_0000_1230, 0, 0);
    chk("b2b_ready", ready, 1'b1);
    txn(40'h00_0000_1240, 0, 0);
    chk("b2b_second_vaddr", resp_vaddr, 40'h00_0000_1240);
    step();

    // Conflict eviction
    txn(40'h00_0000_1630, 0, 0);
    step();
    txn(40'h00_0000_1230, 0, 0);
    step();

    // Kill in MISS_WAIT, then the filled line hits
    txn(40'h00_0000_2000, 2, 0);
    step();
    txn(40'h00_0000_2000, 0, 0);
    step();

    // Invalidate while idle, then invalidate during MISS_WAIT
    idle_inval();
    txn(40'h00_0000_1230, 0, 0);
    step();
    txn(40'h00_0000_2000, 0, 2);
    step();
    txn(40'h00_0000_2000, 0, 0);
    step();

    // Reset while in MISS_REQ, then a stray late memory response
    a = 40'h00_0000_3450;
    req_valid = 1; req_idx = a[11:0]; req_vpn = a[39:12];
    step(); exp_rdy = 0;
    step(); exp_rdy = 0; exp_mreq = 1; exp_maddr = a; rst_i = 1;
    step(); rst_i = 0; exp_mreq = 0; mvalid = '0;
    chk("midmiss_reset_mem_addr", mreq_addr, 40'h0);
    mresp_valid = 1; mresp_data = mem_line(a);
    step();
    step();
    txn(a, 0, 0);
    step();

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) idle_inval();
      else if (r == 1) step();
      else begin
        a = {30'h100 + 30'($urandom_range(0, 2)), 6'($urandom_range(32, 35)), 4'($urandom_range(0, 15))};
        r = $urandom_range(0, 9);
        kph = (r < 3) ? r + 1 : 0;
        r = $urandom_range(0, 11);
        iph = (r < 3) ? r + 1 : 0;
        txn(a, kph, iph);
      end
    end
    step();
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
